// File: rtl/common.sv
// rtl/common.sv - shared memory-stage types and the load alignment helper
package common;

  typedef enum logic [1:0] {MSIZE1, MSIZE2, MSIZE4, MSIZE8} msize_t;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} load_state_t;

  // 1 when an access of the given size cannot start at this byte offset
  function automatic logic MISALIGN(input msize_t msize, input logic [2:0] addr);
    case (msize)
      MSIZE2:  return addr[0];
      MSIZE4:  return |addr[1:0];
      MSIZE8:  return |addr[2:0];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_data.sv
// rtl/load_data.sv - lane select and sign/zero extension of a 64-bit read word
module load_data
  import common::*;
(
  input  msize_t      msize,
  input  logic        is_unsigned,
  input  logic [2:0]  addr,
  input  logic [63:0] data,
  output logic [63:0] result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] word_v;

  assign byte_v = data[{addr, 3'b000} +: 8];
  assign half_v = data[{addr[2:1], 4'b0000} +: 16];
  assign word_v = data[{addr[2], 5'b00000} +: 32];

  always_comb begin
    result = data;
    case (msize)
      MSIZE1:  result = {{56{~is_unsigned & byte_v[7]}}, byte_v};
      MSIZE2:  result = {{48{~is_unsigned & half_v[15]}}, half_v};
      MSIZE4:  result = {{32{~is_unsigned & word_v[31]}}, word_v};
      default: result = data;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// rtl/load_unit.sv - memory-stage load sequencer between the pipeline and the dbus read port
module load_unit
  import common::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] addr,
  input  msize_t      msize,
  input  logic        is_unsigned,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic        misaligned,
  output logic [63:0] result,
  output logic        dreq_valid,
  output logic [63:0] dreq_addr,
  output msize_t      dreq_size,
  input  logic        dresp_addr_ok,
  input  logic        dresp_data_ok,
  input  logic [63:0] dresp_data
);

  load_state_t state;
  logic        lat_unsigned;
  logic [63:0] ext_data;

  // extraction works off the latched request so it lines up with the response
  load_data u_load_data (
    .msize       (dreq_size),
    .is_unsigned (lat_unsigned),
    .addr        (dreq_addr[2:0]),
    .data        (dresp_data),
    .result      (ext_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      misaligned   <= 1'b0;
      result       <= '0;
      dreq_valid   <= 1'b0;
      dreq_addr    <= '0;
      dreq_size    <= MSIZE1;
      lat_unsigned <= 1'b0;
    end else begin
      done       <= 1'b0;
      misaligned <= 1'b0;
      case (state)
        IDLE: begin
          if (!flush && start) begin
            if (MISALIGN(msize, addr[2:0])) begin
              done       <= 1'b1;
              misaligned <= 1'b1;
              result     <= '0;
            end else begin
              state        <= REQ;
              busy         <= 1'b1;
              dreq_valid   <= 1'b1;
              dreq_addr    <= addr;
              dreq_size    <= msize;
              lat_unsigned <= is_unsigned;
            end
          end
        end
        REQ: begin
          if (dresp_addr_ok) begin
            dreq_valid <= 1'b0;
            if (dresp_data_ok) begin
              state <= IDLE;
              busy  <= 1'b0;
              if (!flush) begin
                done   <= 1'b1;
                result <= ext_data;
              end
            end else begin
              state <= flush ? DRAIN : WAIT;
            end
          end else if (flush) begin
            state      <= IDLE;
            busy       <= 1'b0;
            dreq_valid <= 1'b0;
          end
        end
        WAIT: begin
          if (dresp_data_ok) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (!flush) begin
              done   <= 1'b1;
              result <= ext_data;
            end
          end else if (flush) begin
            state <= DRAIN;
          end
        end
        default: begin
          // the bus still owes us a beat; swallow it silently
          if (dresp_data_ok) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_unit.sv
// tb/tb_load_unit.sv - scoreboard bench for load_unit with directed load vectors
module tb_load_unit;
  import common::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [63:0] addr = '0;
  msize_t      msize = MSIZE1;
  logic        is_unsigned = 1'b0;
  logic        flush = 1'b0;
  logic        busy, done, misaligned, dreq_valid;
  logic [63:0] result, dreq_addr;
  msize_t      dreq_size;
  logic        dresp_addr_ok = 1'b0;
  logic        dresp_data_ok = 1'b0;
  logic [63:0] dresp_data = '0;

  int total = 0;
  int bad = 0;
  int vcnt = 0;
  int dcnt = 0;
  logic [64:0] sb_q[$];

  load_unit dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .addr          (addr),
    .msize         (msize),
    .is_unsigned   (is_unsigned),
    .flush         (flush),
    .busy          (busy),
    .done          (done),
    .misaligned    (misaligned),
    .result        (result),
    .dreq_valid    (dreq_valid),
    .dreq_addr     (dreq_addr),
    .dreq_size     (dreq_size),
    .dresp_addr_ok (dresp_addr_ok),
    .dresp_data_ok (dresp_data_ok),
    .dresp_data    (dresp_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset && dreq_valid) vcnt++;
    if (!reset && done) dcnt++;
  end

  // monitor: every done pops one expected {misaligned, result}
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 64'(done), 64'(0));
      end else begin
        logic [64:0] e;
        e = sb_q.pop_front();
        check("sb_misaligned", 64'(misaligned), 64'(e[64]));
        check("sb_result", result, e[63:0]);
      end
    end
  end

  task automatic do_load(input logic [63:0] a, input msize_t s, input logic u,
                         input logic [63:0] d, input int ad, input int dd,
                         input logic [63:0] er, input logic em);
    start = 1'b1;
    addr = a;
    msize = s;
    is_unsigned = u;
    dresp_data = d;
    sb_q.push_back({em, er});
    vcnt = 0;
    step();
    start = 1'b0;
    if (em) begin
      @(negedge clk);
      check("mis_done_cycle1", 64'(done), 64'(1));
      step();
      check("mis_no_dreq", 64'(vcnt), 64'(0));
    end else begin
      for (int i = 0; i < ad; i++) step();
      dresp_addr_ok = 1'b1;
      dresp_data_ok = (dd == 0);
      step();
      dresp_addr_ok = 1'b0;
      dresp_data_ok = 1'b0;
      if (dd > 0) begin
        for (int i = 0; i < dd - 1; i++) step();
        dresp_data_ok = 1'b1;
        step();
        dresp_data_ok = 1'b0;
      end
      @(negedge clk);
      check("done_latency", 64'(done), 64'(1));
      check("dreq_valid_cycles", 64'(vcnt), 64'(ad + 1));
      step();
    end
  endtask

  initial begin
    #12;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_misaligned", 64'(misaligned), 64'(0));
    check("rst_dreq_valid", 64'(dreq_valid), 64'(0));
    check("rst_result", result, 64'h0);
    check("rst_dreq_addr", dreq_addr, 64'h0);
    check("rst_dreq_size", 64'(dreq_size), 64'(MSIZE1));
    step();
    reset = 1'b0;
    step();

    do_load(64'h1003, MSIZE1, 1'b0, 64'h0000_0000_8000_0000, 0, 0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0);
    do_load(64'h1003, MSIZE1, 1'b1, 64'h0000_0000_8000_0000, 0, 0, 64'h0000_0000_0000_0080, 1'b0);
    do_load(64'h2004, MSIZE4, 1'b0, 64'h8765_4321_0000_0000, 0, 0, 64'hFFFF_FFFF_8765_4321, 1'b0);
    do_load(64'h3001, MSIZE2, 1'b0, 64'h1234_5678_9ABC_DEF0, 0, 0, 64'h0, 1'b1);
    do_load(64'h1006, MSIZE2, 1'b0, 64'h8001_0000_0000_0000, 1, 0, 64'hFFFF_FFFF_FFFF_8001, 1'b0);
    do_load(64'h0010, MSIZE4, 1'b1, 64'h0000_0000_F000_0001, 0, 1, 64'h0000_0000_F000_0001, 1'b0);
    do_load(64'h4008, MSIZE8, 1'b0, 64'hDEAD_BEEF_0123_4567, 3, 2, 64'hDEAD_BEEF_0123_4567, 1'b0);

    // flush while waiting for data: response is drained, no done
    dcnt = 0;
    start = 1'b1;
    addr = 64'h5000;
    msize = MSIZE8;
    is_unsigned = 1'b0;
    dresp_data = 64'h5555_AAAA_5555_AAAA;
    step();
    start = 1'b0;
    dresp_addr_ok = 1'b1;
    step();
    dresp_addr_ok = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    dresp_data_ok = 1'b1;
    @(negedge clk);
    check("drain_busy", 64'(busy), 64'(1));
    step();
    dresp_data_ok = 1'b0;
    @(negedge clk);
    check("drain_busy_drop", 64'(busy), 64'(0));
    check("drain_no_done", 64'(dcnt), 64'(0));
    step();
    do_load(64'h6002, MSIZE2, 1'b1, 64'h0000_0000_BEEF_0000, 0, 0, 64'h0000_0000_0000_BEEF, 1'b0);

    // asynchronous reset in REQ
    start = 1'b1;
    addr = 64'h7000;
    msize = MSIZE4;
    step();
    start = 1'b0;
    @(negedge clk);
    check("req_dreq_valid", 64'(dreq_valid), 64'(1));
    #2 reset = 1'b1;
    #1;
    check("async_rst_dreq_valid", 64'(dreq_valid), 64'(0));
    check("async_rst_busy", 64'(busy), 64'(0));
    step();
    reset = 1'b0;
    step();
    do_load(64'h7001, MSIZE1, 1'b0, 64'h0000_0000_0000_7F00, 0, 0, 64'h0000_0000_0000_007F, 1'b0);

    step();
    check("sb_empty", 64'(sb_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_unit.md
# load_unit

Memory-stage load sequencer: accepts one load request from the pipeline, issues a read on the data bus, waits for the response, then extracts the addressed byte, half, word or double and sign- or zero-extends it to 64 bits. It is the read-side counterpart of the memory stage's store formatter, which builds strobes and lane-aligned write data. It sits between the memory pipeline stage and the dbus port, and reports completion, misalignment and busy status back to the pipeline.

## Interface
Parameters: none; widths come from `common`.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: load request; accepted only in IDLE.
- `addr` in 64: byte address of the load.
- `msize` in msize_t: MSIZE1/2/4/8.
- `is_unsigned` in 1: 1 = zero-extend, 0 = sign-extend.
- `flush` in 1: abort the in-flight load; no `done` for it.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle completion pulse.
- `misaligned` out 1: valid with `done`; 1 = no bus access made.
- `result` out 64: extended load data; valid with `done`, held until next accepted `start`.
- `dreq_valid` out 1: bus read request.
- `dreq_addr` out 64: latched `addr`, full byte address.
- `dreq_size` out msize_t: latched `msize`.
- `dresp_addr_ok` in 1: request accepted this cycle.
- `dresp_data_ok` in 1: read data valid this cycle.
- `dresp_data` in 64: aligned 64-bit word containing the address.

## Operation
- States: IDLE, REQ, WAIT, DRAIN.
- IDLE → REQ on `start` with an aligned address. Latch `addr`, `msize` and `is_unsigned`.
- Alignment rules: MSIZE2 needs addr[0]=0, MSIZE4 needs addr[1:0]=0, MSIZE8 needs addr[2:0]=0. MSIZE1 is always aligned.
- IDLE on a misaligned `start`: stay in IDLE. Next cycle pulse `done=1` and `misaligned=1` with `result=0`. No bus request is made.
- REQ: `dreq_valid=1`, held until `dresp_addr_ok`. The address and size stay stable while waiting.
  - `addr_ok` and `data_ok` in the same cycle: capture the data, go to IDLE, pulse `done`.
  - `addr_ok` alone: go to WAIT.
- WAIT: `dreq_valid=0`. On `data_ok`, capture the data, go to IDLE, pulse `done`.
- Extraction from `dresp_data` using latched addr[2:0]:
  - Byte lane = addr[2:0].
  - Half lane = addr[2:1].
  - Word lane = addr[2].
  - Extend bit 7, 15 or 31 per `is_unsigned`. MSIZE8 passes through.
- `flush`:
  - In REQ without `addr_ok`: go to IDLE, deassert `dreq_valid` next cycle.
  - In REQ with `addr_ok`, or in WAIT: go to DRAIN.
  - In DRAIN: stay until `data_ok`, discard the data, go to IDLE, no `done`.
  - If `flush` and `data_ok` arrive together in WAIT: discard the data, go to IDLE, no `done`.
  - `flush` in IDLE takes priority over `start`.
- `start` while `busy` is ignored.
- Reset values: state IDLE; `busy`, `done`, `misaligned`, `dreq_valid` = 0; `result`, `dreq_addr` = 0; `dreq_size` = MSIZE1.
- Reset mid-transaction returns to IDLE immediately. Any later `data_ok` from the bus is the bus's responsibility.

## Timing
- All outputs are registered.
- `start` accepted at edge 0 → `dreq_valid=1` in cycle 1.
- `addr_ok` and `data_ok` in cycle 1 → `done` and `result` in cycle 2. Minimum latency is 2 cycles.
- Each cycle of `addr_ok` or `data_ok` stall adds one cycle of latency.
- Misaligned load: `done` in cycle 1.
- Back-to-back: a new `start` is accepted in the same cycle `done` is high, since state is already IDLE. Throughput is one load per 2 cycles.

## Structure
- `common` package holds:
  - `msize_t` (existing).
  - New `load_state_t` enum {IDLE, REQ, WAIT, DRAIN}.
  - A `MISALIGN` helper function taking (msize, addr[2:0]).
- Sub-module `load_data` holds the combinational lane select and extension:
  - Inputs: msize, is_unsigned, addr[2:0], 64-bit data.
  - Output: 64-bit result.
  - Instantiated once, on the captured response path.

## Test plan
- MSIZE1, signed, addr 0x1003, data 0x0000_0000_8000_0000 (0x80 in byte lane 3), immediate `addr_ok` and `data_ok` → `done` in cycle 2, result 0xFFFF_FFFF_FFFF_FF80. Repeat unsigned → 0x80.
- MSIZE4, signed, addr 0x2004, data 0x8765_4321_0000_0000 → 0xFFFF_FFFF_8765_4321.
- MSIZE2, addr 0x3001 → `done` and `misaligned` in cycle 1, `dreq_valid` never asserted, result 0.
- MSIZE8, `addr_ok` delayed 3 cycles, `data_ok` 2 cycles after that → `dreq_valid` high exactly 4 cycles; `done` 1 cycle after `data_ok`; result equals `dresp_data`.
- `flush` in WAIT, `data_ok` 2 cycles later → DRAIN, no `done`, `busy` drops the cycle after `data_ok`; the next `start` completes normally.
- `reset` asserted asynchronously in REQ → `dreq_valid` and `busy` go low immediately; after release the unit accepts `start` in IDLE.
